// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL / downstream reset domain.
// state_dbg mirrors the supervisor FSM state for observation only.
interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       psram_init;
    logic       fault;
    logic [1:0] retry_cnt;
    logic       lock_ok;
    logic [2:0] state_dbg;

    modport master (
        input  pll_lock,
        output pll_rst,
        output sys_rst_n,
        output psram_init,
        output fault,
        output retry_cnt,
        output lock_ok,
        output state_dbg
    );

    modport slave (
        output pll_lock,
        input  pll_rst,
        input  sys_rst_n,
        input  psram_init,
        input  fault,
        input  retry_cnt,
        input  lock_ok,
        input  state_dbg
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies the synchronized lock flag and releases the downstream
// reset once lock is stable and the PSRAM power-up wait has elapsed; retries on failure.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 2700,
    parameter int LOCK_STABLE    = 256,
    parameter int STARTUP_WAIT   = 4050,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_lock_supervisor_if.master  sup
);
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_STARTUP   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] LD_STARTUP = CNT_W'(STARTUP_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRIES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d, retry_inc;
    logic             lock_meta, lock_s;
    logic             fail;
    logic             pll_rst_q, sys_rst_n_q, psram_init_q, fault_q, lock_ok_q;

    // pll_lock comes from the PLL's own clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= sup.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PLL_RST;
            cnt_q   <= LD_RST;
            retry_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    assign retry_inc = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fail    = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = LD_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = LD_STABLE;
                end else if (cnt_q == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STABLE: begin
                // A drop before qualification is a glitch: re-wait without counting a retry.
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = LD_TIMEOUT;
                end else if (cnt_q == '0) begin
                    state_d = S_STARTUP;
                    cnt_d   = LD_STARTUP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STARTUP: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    fail = 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = LD_RST;
            end
        endcase

        if (fail) begin
            retry_d = retry_inc;
            if (retry_q == RETRY_LAST) begin
                state_d = S_FAULT;
            end else begin
                state_d = S_PLL_RST;
                cnt_d   = LD_RST;
            end
        end
    end

    // Outputs are registered from the next state so nothing combinational reaches the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q    <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            psram_init_q <= 1'b0;
            fault_q      <= 1'b0;
            lock_ok_q    <= 1'b0;
        end else begin
            pll_rst_q    <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
            sys_rst_n_q  <= (state_d == S_RUN);
            psram_init_q <= (state_d == S_RUN) && (state_q != S_RUN);
            fault_q      <= (state_d == S_FAULT);
            lock_ok_q    <= (state_d == S_STARTUP) || (state_d == S_RUN);
        end
    end

    assign sup.pll_rst    = pll_rst_q;
    assign sup.sys_rst_n  = sys_rst_n_q;
    assign sup.psram_init = psram_init_q;
    assign sup.fault      = fault_q;
    assign sup.retry_cnt  = retry_q;
    assign sup.lock_ok    = lock_ok_q;
    assign sup.state_dbg  = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: phase/deadline reference model compared every cycle,
// plus directed timing measurements for clean lock, glitch, timeout, loss and reset cases.
module tb_pll_lock_supervisor;
    localparam int PLL_RST_CYCLES = 16;
    localparam int LOCK_TIMEOUT   = 2700;
    localparam int LOCK_STABLE    = 256;
    localparam int STARTUP_WAIT   = 4050;
    localparam int MAX_RETRIES    = 3;
    // Raw edge -> two synchronizer edges -> edge that samples lock_s, then both windows.
    localparam int RISE_LAT       = 3 + LOCK_STABLE + STARTUP_WAIT;

    localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_START = 3, M_RUN = 4, M_FAULT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pll_lock_supervisor_if sup();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
        .STARTUP_WAIT(STARTUP_WAIT), .MAX_RETRIES(MAX_RETRIES), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sup(sup)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase plus absolute cycle at which the phase window expires.
    int m_phase = M_RST;
    int m_expire = PLL_RST_CYCLES;
    int m_retries = 0;
    int cyc = 0;
    bit m_pulse = 1'b0;
    bit s1 = 1'b0, s2 = 1'b0;

    task automatic m_enter(input int p, input int len);
        m_phase  = p;
        m_expire = cyc + len;
    endtask

    task automatic m_fail();
        if (m_retries == MAX_RETRIES - 1) m_phase = M_FAULT;
        else m_enter(M_RST, PLL_RST_CYCLES);
        if (m_retries < 3) m_retries++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_RST; cyc = 0; m_expire = PLL_RST_CYCLES;
            m_retries = 0; s1 = 1'b0; s2 = 1'b0; m_pulse = 1'b0;
        end else begin
            bit ls;
            cyc++;
            ls = s2; s2 = s1; s1 = sup.pll_lock;
            m_pulse = 1'b0;
            case (m_phase)
                M_RST:   if (cyc == m_expire) m_enter(M_WAIT, LOCK_TIMEOUT);
                M_WAIT:  if (ls) m_enter(M_STAB, LOCK_STABLE);
                         else if (cyc == m_expire) m_fail();
                M_STAB:  if (!ls) m_enter(M_WAIT, LOCK_TIMEOUT);
                         else if (cyc == m_expire) m_enter(M_START, STARTUP_WAIT);
                M_START: if (!ls) m_fail();
                         else if (cyc == m_expire) begin m_phase = M_RUN; m_pulse = 1'b1; end
                M_RUN:   if (!ls) m_fail();
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check_eq("pll_rst", sup.pll_rst, 32'(m_phase == M_RST || m_phase == M_FAULT));
        check_eq("sys_rst_n", sup.sys_rst_n, 32'(m_phase == M_RUN));
        check_eq("psram_init", sup.psram_init, 32'(m_pulse));
        check_eq("fault", sup.fault, 32'(m_phase == M_FAULT));
        check_eq("retry_cnt", sup.retry_cnt, 32'(m_retries));
        check_eq("lock_ok", sup.lock_ok, 32'(m_phase == M_START || m_phase == M_RUN));
    end

    task automatic do_reset();
        sup.pll_lock = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on the negedge where pll_rst is (newly) high; counts edges until it drops.
    task automatic expect_pll_rst_width(input string tag);
        int n = 0;
        while (sup.pll_rst === 1'b1 && n < 200) begin @(negedge clk); n++; end
        check_eq(tag, n, PLL_RST_CYCLES);
    endtask

    // Raises lock and checks the release latency and a single psram_init pulse.
    task automatic raise_and_time(input string tag, output int rst_seen);
        int n = 0;
        int pulses = 0;
        rst_seen = 0;
        sup.pll_lock = 1'b1;
        while (sup.sys_rst_n !== 1'b1 && n < RISE_LAT + 100) begin
            @(negedge clk); n++;
            if (sup.pll_rst === 1'b1) rst_seen++;
            if (sup.psram_init === 1'b1 && sup.sys_rst_n !== 1'b1) pulses++;
        end
        check_eq({tag, "_latency"}, n, RISE_LAT);
        check_eq({tag, "_early_pulse"}, pulses, 0);
        check_eq({tag, "_pulse_on"}, sup.psram_init, 1);
        @(negedge clk);
        check_eq({tag, "_pulse_off"}, sup.psram_init, 0);
        check_eq({tag, "_still_run"}, sup.sys_rst_n, 1);
    endtask

    int n, k, t, t_fall, seen, pulses;
    bit prev;

    initial begin
        sup.pll_lock = 1'b0;

        // Clean lock, then lock loss in RUN and relock.
        do_reset();
        check_eq("reset_sys_rst_n", sup.sys_rst_n, 0);
        expect_pll_rst_width("s1_pll_rst_width");
        repeat (100) @(negedge clk);
        raise_and_time("s1", seen);
        check_eq("s1_retry", sup.retry_cnt, 0);
        check_eq("s1_lock_ok", sup.lock_ok, 1);

        repeat ($urandom_range(10, 200)) @(negedge clk);
        sup.pll_lock = 1'b0;
        n = 0;
        while (sup.sys_rst_n === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check_eq("s4_drop_latency", n, 3);
        check_eq("s4_pll_rst", sup.pll_rst, 1);
        check_eq("s4_retry", sup.retry_cnt, 1);
        expect_pll_rst_width("s4_pll_rst_width");
        repeat ($urandom_range(1, 500)) @(negedge clk);
        raise_and_time("s4_relock", seen);
        check_eq("s4_retry_after", sup.retry_cnt, 1);

        // Glitch during the stable window.
        do_reset();
        expect_pll_rst_width("s2_pll_rst_width");
        repeat ($urandom_range(5, 300)) @(negedge clk);
        sup.pll_lock = 1'b1;
        repeat (3 + 100) @(negedge clk);
        sup.pll_lock = 1'b0;
        seen = 0;
        repeat (3) begin @(negedge clk); if (sup.pll_rst === 1'b1) seen++; end
        raise_and_time("s2_restore", k);
        check_eq("s2_pll_rst_quiet", seen + k, 0);
        check_eq("s2_retry", sup.retry_cnt, 0);

        // Lock never arrives: three timeouts then FAULT.
        do_reset();
        k = 0; prev = 1'b1; t = 0; t_fall = 0;
        while (sup.fault !== 1'b1 && t < 12000) begin
            @(negedge clk); t++;
            if (prev && sup.pll_rst === 1'b0) t_fall = t;
            if (!prev && sup.pll_rst === 1'b1) begin
                k++;
                check_eq("s3_low_span", t - t_fall, LOCK_TIMEOUT);
                check_eq("s3_retry_step", sup.retry_cnt, k);
            end
            prev = sup.pll_rst;
        end
        check_eq("s3_attempts", k, 3);
        repeat (50) @(negedge clk);
        check_eq("s3_fault", sup.fault, 1);
        check_eq("s3_pll_rst_held", sup.pll_rst, 1);
        check_eq("s3_sys_rst_n_held", sup.sys_rst_n, 0);
        check_eq("s3_retry_final", sup.retry_cnt, 3);

        // Lock loss on the final STARTUP count.
        do_reset();
        expect_pll_rst_width("s5_pll_rst_width");
        repeat ($urandom_range(5, 300)) @(negedge clk);
        sup.pll_lock = 1'b1;
        n = 0;
        while (sup.lock_ok !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        check_eq("s5_startup_reached", sup.lock_ok, 1);
        n = 0;
        while (cyc != m_expire - 3 && n < STARTUP_WAIT + 10) begin @(negedge clk); n++; end
        sup.pll_lock = 1'b0;
        pulses = 0; seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sup.psram_init === 1'b1) pulses++;
            if (sup.sys_rst_n === 1'b1) seen++;
        end
        check_eq("s5_no_pulse", pulses, 0);
        check_eq("s5_sys_rst_low", seen, 0);
        check_eq("s5_retry", sup.retry_cnt, 1);

        // Asynchronous reset in the middle of STARTUP.
        do_reset();
        expect_pll_rst_width("s6_pll_rst_width");
        repeat ($urandom_range(5, 300)) @(negedge clk);
        sup.pll_lock = 1'b1;
        n = 0;
        while (sup.lock_ok !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        repeat ($urandom_range(10, 3000)) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sup.pll_lock = 1'b0;
        #1;
        check_eq("s6_async_pll_rst", sup.pll_rst, 1);
        check_eq("s6_async_sys_rst_n", sup.sys_rst_n, 0);
        check_eq("s6_async_psram", sup.psram_init, 0);
        check_eq("s6_async_fault", sup.fault, 0);
        check_eq("s6_async_retry", sup.retry_cnt, 0);
        check_eq("s6_async_lock_ok", sup.lock_ok, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_pll_rst_width("s6_restart_width");
        repeat ($urandom_range(5, 300)) @(negedge clk);
        raise_and_time("s6_relock", seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
